// File: rtl/rf_read_arbiter_pkg.sv
// Shared widths for the register-file read arbiter and its helpers.
package rf_read_arbiter_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ID_W      = 5;
  localparam int unsigned ROB_INDEX_BIT = 4;

endpackage

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward, pointer moves past each accepted grant.
module rf_read_arbiter_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW:0]   nxt;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = advance;
        index       = cand;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, index} + (IW+1)'(1);
    if (nxt >= (IW+1)'(N)) nxt = '0;
    ptr_d = (advance && found) ? nxt[IW-1:0] : ptr_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Shares the RF's two read ports among N_REQ requesters; registered operand pair with commit bypass.
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned ROB_INDEX_BIT = rf_read_arbiter_pkg::ROB_INDEX_BIT,
  localparam int unsigned WHO_W        = $clog2(N_REQ)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [REG_ID_W*N_REQ-1:0]  req_rs1,
  input  logic [REG_ID_W*N_REQ-1:0]  req_rs2,
  output logic [N_REQ-1:0]           req_grant,
  output logic                       resp_valid,
  output logic [WHO_W-1:0]           resp_who,
  output logic [XLEN-1:0]            resp_val1,
  output logic [XLEN-1:0]            resp_val2,
  output logic [ROB_INDEX_BIT-1:0]   resp_dep1,
  output logic [ROB_INDEX_BIT-1:0]   resp_dep2,
  output logic                       resp_has_dep1,
  output logic                       resp_has_dep2,
  output logic [REG_ID_W-1:0]        rf_req_id1,
  output logic [REG_ID_W-1:0]        rf_req_id2,
  input  logic [XLEN-1:0]            rf_val1,
  input  logic [XLEN-1:0]            rf_val2,
  input  logic [ROB_INDEX_BIT-1:0]   rf_dep1,
  input  logic [ROB_INDEX_BIT-1:0]   rf_dep2,
  input  logic                       rf_has_dep1,
  input  logic                       rf_has_dep2,
  input  logic                       cm_valid,
  input  logic [REG_ID_W-1:0]        cm_rd,
  input  logic [XLEN-1:0]            cm_value,
  input  logic [ROB_INDEX_BIT-1:0]   cm_rob_id
);

  logic             go;
  logic [WHO_W-1:0] gnt_idx;
  logic             any_grant;
  logic             byp1, byp2;

  // Reset also gates the grant so nothing is accepted while the pointer is forced to 0.
  assign go = rdy_in && !clear && !rst_in;

  rf_read_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     (req_valid),
    .advance (go),
    .grant   (req_grant),
    .index   (gnt_idx)
  );

  assign any_grant = |req_grant;

  always_comb begin
    rf_req_id1 = '0;
    rf_req_id2 = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_grant[i]) begin
        rf_req_id1 = req_rs1[REG_ID_W*i +: REG_ID_W];
        rf_req_id2 = req_rs2[REG_ID_W*i +: REG_ID_W];
      end
    end
  end

  // Only a pending operand whose producer is committing right now may take the commit value.
  assign byp1 = cm_valid && (cm_rd == rf_req_id1) && rf_has_dep1 && (rf_dep1 == cm_rob_id);
  assign byp2 = cm_valid && (cm_rd == rf_req_id2) && rf_has_dep2 && (rf_dep2 == cm_rob_id);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_valid    <= 1'b0;
      resp_who      <= '0;
      resp_val1     <= '0;
      resp_val2     <= '0;
      resp_dep1     <= '0;
      resp_dep2     <= '0;
      resp_has_dep1 <= 1'b0;
      resp_has_dep2 <= 1'b0;
    end else if (rdy_in) begin
      resp_valid <= any_grant;
      if (any_grant) begin
        resp_who <= gnt_idx;
        if (rf_req_id1 == '0 || byp1) begin
          resp_val1     <= (rf_req_id1 == '0) ? '0 : cm_value;
          resp_dep1     <= '0;
          resp_has_dep1 <= 1'b0;
        end else begin
          resp_val1     <= rf_val1;
          resp_dep1     <= rf_dep1;
          resp_has_dep1 <= rf_has_dep1;
        end
        if (rf_req_id2 == '0 || byp2) begin
          resp_val2     <= (rf_req_id2 == '0) ? '0 : cm_value;
          resp_dep2     <= '0;
          resp_has_dep2 <= 1'b0;
        end else begin
          resp_val2     <= rf_val2;
          resp_dep2     <= rf_dep2;
          resp_has_dep2 <= rf_has_dep2;
        end
      end
    end
  end

endmodule
